depatchifier: RTL and testbench
===============================

DEPATCHIFIER -- requirements
Module: depatchifier

Interface
REQ-001 SHALL have parameter CHANNEL_SIZE, default 8, bits per colour channel.
REQ-002 SHALL have parameter NUM_CHANNELS, default 3, channels per pixel (RGB).
REQ-003 SHALL have parameter PIXEL_WIDTH, default CHANNEL_SIZE*NUM_CHANNELS, bits per pixel.
REQ-004 SHALL have parameter SIZE, default 16, patch edge length in pixels.
REQ-005 SHALL have parameter PATCH_VECTOR_SIZE, default SIZE*SIZE, pixels per patch.
REQ-006 SHALL have port clk  input  1  clock; all logic on its rising edge.
REQ-007 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port en  input  1  start request, sampled only in IDLE.
REQ-009 SHALL have port in_valid  input  1  in_pixel holds a valid vector element.
REQ-010 SHALL have port in_pixel  input  PIXEL_WIDTH  next element of the vectorized patch, index order 0..PATCH_VECTOR_SIZE-1.
REQ-011 SHALL have port in_ready  output  1  block accepts an element this cycle.
REQ-012 SHALL have port output_taken  input  1  consumer has taken patch_out, sampled only in DONE.
REQ-013 SHALL have port state  output  2  FSM state: IDLE=2'b00, LOADING=2'b01, DONE=2'b10.
REQ-014 SHALL have port count  output  $clog2(PATCH_VECTOR_SIZE)+1  number of elements accepted in the current patch.
REQ-015 SHALL have port patch_out  output  PIXEL_WIDTH x [SIZE][SIZE]  reassembled 2D patch, indexed [row][col].
REQ-016 SHALL have port out_valid  output  1  patch_out is complete and stable.

Function
REQ-017 SHALL implement FSM IDLE -> LOADING on en; LOADING -> DONE on acceptance of element PATCH_VECTOR_SIZE-1; DONE -> IDLE on output_taken; no other transitions.
REQ-018 SHALL drive in_ready = 1 only in LOADING, combinationally from state.
REQ-019 SHALL accept an element in a cycle where in_valid && in_ready; no acceptance in any other cycle.
REQ-020 SHALL, for accepted element k, write in_pixel to patch_out[k / SIZE][k % SIZE] at the clock edge ending that cycle (row-major, inverse of the flattening index k = row*SIZE + col).
REQ-021 SHALL keep row/col counters: col increments per accepted element, wraps SIZE-1 -> 0 with row increment; row wraps to 0 after final element.
REQ-022 SHALL increment count by 1 per accepted element; count = PATCH_VECTOR_SIZE in DONE.
REQ-023 SHALL tolerate arbitrary in_valid gaps in LOADING: counters, buffer, and state hold while in_valid = 0.
REQ-024 SHALL enter DONE the cycle after the last element is accepted (latency 1 cycle from last beat to out_valid = 1).
REQ-025 SHALL drive out_valid = 1 exactly when state == DONE; patch_out SHALL be unchanging while in DONE.
REQ-026 SHALL ignore en in LOADING and DONE, and ignore output_taken in IDLE and LOADING.
REQ-027 SHALL, on DONE with output_taken, clear every patch_out entry, row, col, count to 0 on that edge and enter IDLE.
REQ-028 SHALL, if en and in_valid are high together in IDLE, not accept in_pixel that cycle (in_ready = 0 in IDLE).

Reset
REQ-029 SHALL, on reset, set state = IDLE, row = col = count = 0, every patch_out entry = 0, out_valid = 0, in_ready = 0.
REQ-030 SHALL give reset priority over all other inputs, including mid-LOADING and in DONE; a partial patch is discarded.

Configuration
REQ-031 SHALL, when macro DEPATCHIFIER_TRANSPOSE_EN is defined, write element k to patch_out[k % SIZE][k / SIZE] (column-major fill, transposed patch); all other behaviour unchanged.
REQ-032 SHALL, when DEPATCHIFIER_TRANSPOSE_EN is undefined, use the row-major mapping of REQ-020.

Verification
REQ-033 SHALL cover: reset, en=1, then 256 back-to-back beats with in_pixel = k -> out_valid=1 one cycle after beat 255, patch_out[r][c] = 16r+c, count = 256.
REQ-034 SHALL cover: same stream with in_valid low every other cycle -> identical patch_out, DONE reached after 511 LOADING cycles.
REQ-035 SHALL cover: in DONE, hold output_taken=0 for 10 cycles while toggling en and in_valid -> patch_out, state unchanged; then output_taken=1 -> state=IDLE, patch_out all 0 next cycle.
REQ-036 SHALL cover: reset asserted after 100 accepted beats -> state=IDLE, count=0, patch_out all 0; new load of 256 beats completes correctly.
REQ-037 SHALL cover: with DEPATCHIFIER_TRANSPOSE_EN defined, in_pixel = k -> patch_out[r][c] = 16c+r.
REQ-038 SHALL cover: en=1 and in_valid=1 with in_pixel=24'hABCDEF in the same IDLE cycle -> not accepted, count=0 on entry to LOADING.

Source files
------------

// File: rtl/depatchifier.sv
// depatchifier: rebuilds a SIZE x SIZE pixel patch from a vectorized stream.
// Element k of the stream lands at patch_out[k / SIZE][k % SIZE] (row-major).
// Optional build macro DEPATCHIFIER_TRANSPOSE_EN: element k lands at
// patch_out[k % SIZE][k / SIZE] instead, producing the transposed patch.
// FSM: IDLE --en--> LOADING --last element--> DONE --output_taken--> IDLE.
module depatchifier #(
    parameter int CHANNEL_SIZE      = 8,
    parameter int NUM_CHANNELS      = 3,
    parameter int PIXEL_WIDTH       = CHANNEL_SIZE * NUM_CHANNELS,
    parameter int SIZE              = 16,
    parameter int PATCH_VECTOR_SIZE = SIZE * SIZE
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         en,
    input  logic                                         in_valid,
    input  logic [PIXEL_WIDTH-1:0]                       in_pixel,
    output logic                                         in_ready,
    input  logic                                         output_taken,
    output logic [1:0]                                   state,
    output logic [$clog2(PATCH_VECTOR_SIZE):0]           count,
    output logic [SIZE-1:0][SIZE-1:0][PIXEL_WIDTH-1:0]   patch_out,
    output logic                                         out_valid
);

    localparam int COUNT_W = $clog2(PATCH_VECTOR_SIZE) + 1;
    localparam int IDX_W   = (SIZE > 1) ? $clog2(SIZE) : 1;

    localparam logic [COUNT_W-1:0] LAST_INDEX = COUNT_W'(PATCH_VECTOR_SIZE - 1);
    localparam logic [IDX_W-1:0]   LAST_POS   = IDX_W'(SIZE - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        LOADING = 2'b01,
        DONE    = 2'b10
    } state_t;

    state_t             current_state;
    state_t             next_state;
    logic [IDX_W-1:0]   row;
    logic [IDX_W-1:0]   col;
    logic               accept;
    logic               clear;

    assign state = current_state;

    // State register; reset wins over every other input and drops a partial patch.
    always_ff @(posedge clk) begin
        if (reset) begin
            current_state <= IDLE;
        end else begin
            current_state <= next_state;
        end
    end

    // Next-state and handshake decode; in_ready/out_valid depend only on state.
    always_comb begin
        next_state = current_state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        clear      = 1'b0;
        case (current_state)
            IDLE: begin
                if (en) begin
                    next_state = LOADING;
                end
            end
            LOADING: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (in_valid && (count == LAST_INDEX)) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (output_taken) begin
                    clear      = 1'b1;
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Patch buffer and position counters: write on each accepted beat, wipe on hand-off.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            patch_out <= '0;
            row       <= '0;
            col       <= '0;
            count     <= '0;
        end else if (accept) begin
`ifdef DEPATCHIFIER_TRANSPOSE_EN
            patch_out[col][row] <= in_pixel;
`else
            patch_out[row][col] <= in_pixel;
`endif
            count <= count + 1'b1;
            if (col == LAST_POS) begin
                col <= '0;
                row <= (row == LAST_POS) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_depatchifier.sv
// tb_depatchifier: directed self-checking bench for depatchifier (default parameters).
// Build with DEPATCHIFIER_TRANSPOSE_EN defined to check the transposed mapping.
module tb_depatchifier;

    localparam int PW   = 24;
    localparam int SZ   = 16;
    localparam int NPIX = SZ * SZ;

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_LOADING = 2'b01;
    localparam logic [1:0] ST_DONE    = 2'b10;

    logic                          clk;
    logic                          reset;
    logic                          en;
    logic                          in_valid;
    logic [PW-1:0]                 in_pixel;
    logic                          in_ready;
    logic                          output_taken;
    logic [1:0]                    state;
    logic [8:0]                    count;
    logic [SZ-1:0][SZ-1:0][PW-1:0] patch_out;
    logic                          out_valid;

    int numChecks = 0;
    int numFails  = 0;

    depatchifier dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .in_valid     (in_valid),
        .in_pixel     (in_pixel),
        .in_ready     (in_ready),
        .output_taken (output_taken),
        .state        (state),
        .count        (count),
        .patch_out    (patch_out),
        .out_valid    (out_valid)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, then step past the rising edge so outputs can be sampled.
    task automatic applyStimulus(input logic rst, input logic start, input logic valid,
                                 input logic [PW-1:0] pixel, input logic taken);
        reset        = rst;
        en           = start;
        in_valid     = valid;
        in_pixel     = pixel;
        output_taken = taken;
        @(posedge clk);
        #1;
    endtask

    // Expected content of a full patch loaded with in_pixel = k.
    function automatic logic [PW-1:0] expectedPixel(input int r, input int c);
`ifdef DEPATCHIFIER_TRANSPOSE_EN
        return PW'(16 * c + r);
`else
        return PW'(16 * r + c);
`endif
    endfunction

    task automatic checkPatchFull(input string tag);
        for (int r = 0; r < SZ; r++) begin
            for (int c = 0; c < SZ; c++) begin
                checkOutput($sformatf("%s[%0d][%0d]", tag, r, c), 64'(patch_out[r][c]), 64'(expectedPixel(r, c)));
            end
        end
    endtask

    task automatic checkPatchZero(input string tag);
        for (int r = 0; r < SZ; r++) begin
            for (int c = 0; c < SZ; c++) begin
                checkOutput($sformatf("%s[%0d][%0d]", tag, r, c), 64'(patch_out[r][c]), 64'd0);
            end
        end
    endtask

    // Stream elements 0..NPIX-1 (optionally with an idle cycle between beats), checking entry into DONE.
    task automatic loadPatch(input string tag, input bit gaps);
        int loadCycles;
        loadCycles = 0;
        for (int k = 0; k < NPIX; k++) begin
            if (k == NPIX - 1) begin
                checkOutput({tag, "_state_before_last"}, 64'(state), 64'(ST_LOADING));
                checkOutput({tag, "_valid_before_last"}, 64'(out_valid), 64'd0);
            end
            applyStimulus(1'b0, 1'b0, 1'b1, PW'(k), 1'b0);
            loadCycles++;
            if (gaps && k != NPIX - 1) begin
                applyStimulus(1'b0, 1'b0, 1'b0, 24'h5A5A5A, 1'b0);
                loadCycles++;
                if (k < 3) begin
                    checkOutput($sformatf("%s_gap_count%0d", tag, k), 64'(count), 64'(k + 1));
                    checkOutput($sformatf("%s_gap_state%0d", tag, k), 64'(state), 64'(ST_LOADING));
                end
            end
        end
        checkOutput({tag, "_state_done"}, 64'(state), 64'(ST_DONE));
        checkOutput({tag, "_out_valid"}, 64'(out_valid), 64'd1);
        checkOutput({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        checkOutput({tag, "_count"}, 64'(count), 64'd256);
        checkOutput({tag, "_load_cycles"}, 64'(loadCycles), gaps ? 64'd511 : 64'd256);
        checkPatchFull({tag, "_patch"});
    endtask

    // Release the patch from DONE and confirm everything is wiped.
    task automatic takeOutput(input string tag);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
        checkOutput({tag, "_state"}, 64'(state), 64'(ST_IDLE));
        checkOutput({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        checkOutput({tag, "_count"}, 64'(count), 64'd0);
        checkPatchZero({tag, "_patch"});
    endtask

    // Main directed sequence.
    initial begin
        reset = 1'b1; en = 1'b0; in_valid = 1'b0; in_pixel = '0; output_taken = 1'b0;

        // Reset state
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 24'h123456, 1'b1);
        checkOutput("rst_state", 64'(state), 64'(ST_IDLE));
        checkOutput("rst_count", 64'(count), 64'd0);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
        checkPatchZero("rst_patch");

        // output_taken in IDLE is ignored
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
        checkOutput("idle_taken_state", 64'(state), 64'(ST_IDLE));

        // en and in_valid together in IDLE: pixel must not be accepted
        applyStimulus(1'b0, 1'b1, 1'b1, 24'hABCDEF, 1'b0);
        checkOutput("start_state", 64'(state), 64'(ST_LOADING));
        checkOutput("start_count", 64'(count), 64'd0);
        checkOutput("start_in_ready", 64'(in_ready), 64'd1);
        checkOutput("start_patch00", 64'(patch_out[0][0]), 64'd0);

        // Back-to-back full load
        loadPatch("b2b", 1'b0);

        // Ten cycles in DONE with en/in_valid toggling and output_taken low
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'(i % 2), 1'((i + 1) % 2), PW'($urandom), 1'b0);
            checkOutput($sformatf("hold_state%0d", i), 64'(state), 64'(ST_DONE));
        end
        checkOutput("hold_count", 64'(count), 64'd256);
        checkPatchFull("hold_patch");
        takeOutput("take1");

        // Load with in_valid low every other cycle
        applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0);
        checkOutput("gap_start_state", 64'(state), 64'(ST_LOADING));
        loadPatch("gap", 1'b1);
        takeOutput("take2");

        // Partial load of 100 beats with output_taken held high, then reset mid-LOADING
        applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0);
        for (int k = 0; k < 100; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, PW'(k), 1'b1);
        end
        checkOutput("part_state", 64'(state), 64'(ST_LOADING));
        checkOutput("part_count", 64'(count), 64'd100);
`ifdef DEPATCHIFIER_TRANSPOSE_EN
        checkOutput("part_pix99", 64'(patch_out[3][6]), 64'd99);
`else
        checkOutput("part_pix99", 64'(patch_out[6][3]), 64'd99);
`endif
        applyStimulus(1'b1, 1'b1, 1'b1, 24'hFFFFFF, 1'b0);
        checkOutput("midrst_state", 64'(state), 64'(ST_IDLE));
        checkOutput("midrst_count", 64'(count), 64'd0);
        checkOutput("midrst_in_ready", 64'(in_ready), 64'd0);
        checkPatchZero("midrst_patch");

        // Fresh complete load after the reset
        applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0);
        loadPatch("reload", 1'b0);

        // Reset while in DONE
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
        checkOutput("donerst_state", 64'(state), 64'(ST_IDLE));
        checkOutput("donerst_out_valid", 64'(out_valid), 64'd0);
        checkPatchZero("donerst_patch");

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
